// File: rtl/branch_redirect_ctrl.sv
// PC redirect / pipeline flush sequencer for taken EX-stage branches and jumps.
// Optional BRANCH_STATS_EN adds saturating redirect and flush-cycle counters.
module branch_redirect_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [31:0]     ex_instr,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            stall,
    input  logic            fetch_ready,
    output logic            pc_sel,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if,
    output logic            flush_id,
    output logic            busy,
    output logic            misalign,
    output logic [31:0]     stat_redirects,
    output logic [31:0]     stat_flush_cycles
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_REDIRECT = 2'd1;
    localparam logic [1:0] S_DRAIN    = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_capture;
    logic             w_is_cf;
    logic             w_redirect_req;
    logic             r_pc_sel;
    logic             r_flush_if;
    logic             r_flush_id;
    logic             r_busy;
    logic             r_misalign;
    logic [XLEN-1:0]  r_redirect_pc;
    logic             w_unused;

    assign w_unused = &{1'b0, ex_instr[31:15], ex_instr[11:7]};

    // Only BRANCH, JAL and JALR (funct3 000) may redirect; ex_taken is stale otherwise
    assign w_is_cf = (ex_instr[6:0] == 7'b1100011) ||
                     (ex_instr[6:0] == 7'b1101111) ||
                     ((ex_instr[6:0] == 7'b1100111) && (ex_instr[14:12] == 3'b000));
    assign w_redirect_req = ex_valid & ex_taken & w_is_cf & ~stall;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_redirect_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_REDIRECT;
                end
            end
            S_REDIRECT: begin
                if (fetch_ready) begin
                    if (DRAIN_INIT == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = DRAIN_INIT;
                    end
                end
            end
            S_DRAIN: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State plus outputs registered from the next-state decode
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pc_sel      <= 1'b0;
            r_flush_if    <= 1'b0;
            r_flush_id    <= 1'b0;
            r_busy        <= 1'b0;
            r_misalign    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pc_sel   <= (w_state_nxt == S_REDIRECT);
            r_flush_if <= (w_state_nxt != S_IDLE);
            r_flush_id <= (w_state_nxt == S_REDIRECT);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_misalign <= w_capture & (ex_target[1:0] != 2'b00);
            if (w_capture) begin
                r_redirect_pc <= {ex_target[XLEN-1:2], 2'b00};
            end
        end
    end

    assign pc_sel      = r_pc_sel;
    assign flush_if    = r_flush_if;
    assign flush_id    = r_flush_id;
    assign busy        = r_busy;
    assign misalign    = r_misalign;
    assign redirect_pc = r_redirect_pc;

`ifdef BRANCH_STATS_EN
    logic        w_handshake;
    logic [31:0] r_stat_redirects;
    logic [31:0] r_stat_flush_cycles;

    assign w_handshake = (r_state == S_REDIRECT) & fetch_ready;

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_redirects    <= '0;
            r_stat_flush_cycles <= '0;
        end else begin
            if (w_handshake && (r_stat_redirects != 32'hFFFF_FFFF)) begin
                r_stat_redirects <= r_stat_redirects + 32'd1;
            end
            if (r_flush_if && (r_stat_flush_cycles != 32'hFFFF_FFFF)) begin
                r_stat_flush_cycles <= r_stat_flush_cycles + 32'd1;
            end
        end
    end

    assign stat_redirects    = r_stat_redirects;
    assign stat_flush_cycles = r_stat_flush_cycles;
`else
    assign stat_redirects    = 32'd0;
    assign stat_flush_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed self-checking bench for branch_redirect_ctrl (default DRAIN_CYCLES=2).
module tb_branch_redirect_ctrl;

    localparam logic [31:0] I_BEQ    = 32'h0000_0063;
    localparam logic [31:0] I_BNE    = 32'h0000_1063;
    localparam logic [31:0] I_JAL    = 32'h0000_006F;
    localparam logic [31:0] I_JALR   = 32'h0000_0067;
    localparam logic [31:0] I_JALR_X = 32'h0000_1067;
    localparam logic [31:0] I_ADDI   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_instr;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        stall;
    logic        fetch_ready;
    logic        pc_sel;
    logic [31:0] redirect_pc;
    logic        flush_if;
    logic        flush_id;
    logic        busy;
    logic        misalign;
    logic [31:0] stat_redirects;
    logic [31:0] stat_flush_cycles;

    int n_total = 0;
    int n_bad   = 0;

    branch_redirect_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .ex_instr          (ex_instr),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .stall             (stall),
        .fetch_ready       (fetch_ready),
        .pc_sel            (pc_sel),
        .redirect_pc       (redirect_pc),
        .flush_if          (flush_if),
        .flush_id          (flush_id),
        .busy              (busy),
        .misalign          (misalign),
        .stat_redirects    (stat_redirects),
        .stat_flush_cycles (stat_flush_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic taken, input logic [31:0] tgt);
        ex_valid  = 1'b1;
        ex_instr  = instr;
        ex_taken  = taken;
        ex_target = tgt;
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
        ex_taken = 1'b0;
        ex_instr = I_ADDI;
    endtask

    task automatic check_ctl(input string tag, input logic ps, input logic fi,
                             input logic fd, input logic bz);
        check({tag, ".pc_sel"},   {31'd0, pc_sel},   {31'd0, ps});
        check({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, fi});
        check({tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, fd});
        check({tag, ".busy"},     {31'd0, busy},     {31'd0, bz});
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        fetch_ready = 1'b1;
        ex_target   = 32'd0;
        idle_ex();
        tick();
        tick();
        rst = 1'b0;

        check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.redirect_pc", redirect_pc, 32'd0);
        check("reset.misalign", {31'd0, misalign}, 32'd0);
        check("reset.stat_redirects", stat_redirects, 32'd0);
        check("reset.stat_flush", stat_flush_cycles, 32'd0);

        // Taken BEQ, fetch ready immediately
        present(I_BEQ, 1'b1, 32'h100);
        tick();
        idle_ex();
        check_ctl("beq.redir", 1'b1, 1'b1, 1'b1, 1'b1);
        check("beq.redirect_pc", redirect_pc, 32'h100);
        check("beq.misalign", {31'd0, misalign}, 32'd0);
        tick();
        check_ctl("beq.drain1", 1'b0, 1'b1, 1'b0, 1'b1);
        check("beq.drain_pc_hold", redirect_pc, 32'h100);
        tick();
        check_ctl("beq.drain2", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_ctl("beq.idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Stale taken on non-control-flow opcodes is ignored
        present(I_ADDI, 1'b1, 32'h180);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("addi.pc_sel", {31'd0, pc_sel}, 32'd0);
            check("addi.busy", {31'd0, busy}, 32'd0);
        end
        present(I_JALR_X, 1'b1, 32'h180);
        tick();
        check("jalr_f3.busy", {31'd0, busy}, 32'd0);
        idle_ex();

        // JAL with fetch_ready low for 3 cycles
        fetch_ready = 1'b0;
        present(I_JAL, 1'b1, 32'h200);
        tick();
        idle_ex();
        for (int i = 0; i < 4; i++) begin
            check("jal.hold.pc_sel", {31'd0, pc_sel}, 32'd1);
            check("jal.hold.redirect_pc", redirect_pc, 32'h200);
            fetch_ready = (i == 3);
            tick();
        end
        present(I_JAL, 1'b1, 32'h300);
        check_ctl("jal.drain1", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        check_ctl("jal.drain2", 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        idle_ex();
        check_ctl("jal.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        check("jal.ignored_pc", redirect_pc, 32'h200);

        // Misaligned JALR target
        present(I_JALR, 1'b1, 32'h203);
        tick();
        idle_ex();
        check("jalr.misalign", {31'd0, misalign}, 32'd1);
        check("jalr.redirect_pc", redirect_pc, 32'h200);
        check("jalr.pc_sel", {31'd0, pc_sel}, 32'd1);
        tick();
        check("jalr.misalign_off", {31'd0, misalign}, 32'd0);
        tick();
        tick();
        check("jalr.idle_busy", {31'd0, busy}, 32'd0);

        // BNE blocked by stall, then reset during REDIRECT
        present(I_BNE, 1'b1, 32'h400);
        stall = 1'b1;
        tick();
        check("bne.stall1", {31'd0, pc_sel}, 32'd0);
        tick();
        check("bne.stall2", {31'd0, busy}, 32'd0);
        stall = 1'b0;
        tick();
        idle_ex();
        fetch_ready = 1'b0;
        check("bne.pc_sel", {31'd0, pc_sel}, 32'd1);
        check("bne.redirect_pc", redirect_pc, 32'h400);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetch_ready = 1'b1;
        check_ctl("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid.redirect_pc", redirect_pc, 32'd0);
        check("rst_mid.stat_redirects", stat_redirects, 32'd0);
        check("rst_mid.stat_flush", stat_flush_cycles, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_mid.no_pc_sel", {31'd0, pc_sel}, 32'd0);
        end

        // Three back-to-back redirects for the statistics counters
        for (int k = 0; k < 3; k++) begin
            present(I_BEQ, 1'b1, 32'h500 + 32'(k * 16));
            tick();
            idle_ex();
            check("stats.redirect_pc", redirect_pc, 32'h500 + 32'(k * 16));
            tick();
            tick();
            tick();
        end
        check("stats.busy", {31'd0, busy}, 32'd0);
`ifdef BRANCH_STATS_EN
        check("stats.redirects", stat_redirects, 32'd3);
        check("stats.flush_cycles", stat_flush_cycles, 32'd9);
`else
        check("stats.redirects", stat_redirects, 32'd0);
        check("stats.flush_cycles", stat_flush_cycles, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
